aud_trace_ctrl: RTL and testbench
=================================

// Module: aud_trace_ctrl
// PURPOSE
//  Capture sequencer for the AUD branch-trace path. Takes per-branch events from the aud_btm
//  receiver (already resynchronised to clk), arms/triggers/stops a circular trace buffer
//  on address match, then hands the buffer to the host read interface oldest-entry-first.
//  Sits between the AUD core and the host bridge; owns the single trace RAM.
// PARAMETERS
//  AW          9    log2 of buffer depth (DEPTH = 2**AW entries)
//  ADDR_W      32   branch address width
// PORTS
//  clk         in   1       system clock
//  rst         in   1       reset, asynchronous, active-high
//  evt_stb     in   1       one-cycle pulse: new branch event
//  evt_addr    in   ADDR_W  branch address of event
//  evt_valid   in   1       address complete (aud_btm addr_valid)
//  evt_err     in   1       AUD bus error flag at event
//  cmd_arm     in   1       pulse: IDLE/DONE -> ARMED, clears buffer
//  cmd_stop    in   1       pulse: force DONE from ARMED/CAPTURE
//  cmd_clear   in   1       pulse: abort to IDLE, clear buffer
//  trig_addr   in   ADDR_W  trigger address
//  trig_mask   in   ADDR_W  1 = bit compared
//  post_cnt    in   AW      entries stored after trigger entry
//  state       out  2       0 IDLE,1 ARMED,2 CAPTURE,3 DONE
//  triggered   out  1       trigger seen since last arm
//  fill        out  AW+1    entries held, saturates at DEPTH
//  rd_data     out  ADDR_W+2 {err,valid,addr} (+16 ts if TS_EN)
//  rd_valid    out  1       rd_data valid
//  rd_ready    in   1       host accepts rd_data
// BEHAVIOUR
//  - Reset: state=IDLE, triggered=0, fill=0, rd_valid=0, rd_data=0, wr/rd pointers=0.
//  - Priority per cycle: cmd_clear > cmd_stop > cmd_arm > trigger/event logic.
//  - IDLE: events ignored. cmd_arm -> ARMED; fill=0, wr_ptr=0, triggered=0.
//  - ARMED: each evt_stb writes entry at wr_ptr, wr_ptr++ (wraps mod DEPTH, overwrites oldest),
//    fill++ saturating at DEPTH. Trigger = evt_stb & evt_valid & ((evt_addr^trig_addr)&trig_mask)==0;
//    trigger entry is written, triggered=1, post counter loads post_cnt, -> CAPTURE
//    (post_cnt==0 -> straight to DONE next cycle).
//  - CAPTURE: each evt_stb writes entry, post counter--; write that takes it to 0 -> DONE.
//    Further trigger matches ignored.
//  - evt_err=1 or evt_valid=0 entries are stored but never trigger.
//  - cmd_stop in ARMED/CAPTURE -> DONE; evt_stb in same cycle is still written first.
//  - cmd_arm in ARMED/CAPTURE ignored; cmd_stop in IDLE/DONE ignored.
//  - DONE: no writes. rd_ptr = wr_ptr - fill (mod DEPTH). RAM read latency 1:
//    rd_valid rises 2 clk after DONE entry. On rd_valid&rd_ready: fill--, rd_ptr++, rd_valid=0
//    next cycle, re-asserts the cycle after if fill!=0 (1 entry / 2 clk). rd_data held stable
//    while rd_valid&!rd_ready. fill==0 -> rd_valid stays 0, state stays DONE until cmd_arm/clear.
//  - cmd_clear/cmd_arm mid-readout: rd_valid drops next cycle, pending entry discarded.
//  - rd_valid=0 in all states except DONE. Async rst mid-capture returns all to reset values;
//    RAM contents undefined but unreadable (fill=0).
// CONFIGURATION
//  - AUD_TRACE_TS_EN defined: 16-bit free-running cycle counter (reset 0, wraps); each entry
//    stores counter value at evt_stb in rd_data[ADDR_W+17:ADDR_W+2]; counter clears on cmd_arm.
//  - Not defined: rd_data is ADDR_W+2 bits, no counter logic.
// TESTING
//  - Arm, 5 events, trig_mask=0 (match any valid) post_cnt=3 -> CAPTURE after 1st, DONE after
//    4th; 5th ignored; fill=4; reads return events 1..4 in order.
//  - Arm, 700 events no match, stop (AW=9) -> fill=512; first read = event 189, last = event 700.
//  - trig_addr=0x0C001000 mask=0xFFFFFFF0, event 0x0C00100C with evt_valid=0 -> no trigger;
//    same with evt_valid=1 -> triggered=1, state=CAPTURE.
//  - DONE, fill=2, rd_ready held 0 for 10 clk -> rd_data stable; then rd_ready=1 -> 2 handshakes
//    2 clk apart, fill=0, rd_valid=0.
//  - cmd_stop coincident with evt_stb in ARMED -> entry stored, state=DONE, fill incremented.
//  - rst asserted during CAPTURE -> state=IDLE, fill=0, rd_valid=0 immediately (async).

Source files
------------

// File: rtl/aud_trace_ctrl.sv
// AUD branch-trace capture sequencer: arm/trigger/stop a circular trace RAM, then drain it oldest-first.
// Optional per-entry 16-bit cycle timestamp when AUD_TRACE_TS_EN is defined.
module aud_trace_ctrl #(
  parameter int AW     = 9,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              evt_stb_i,
  input  logic [ADDR_W-1:0] evt_addr_i,
  input  logic              evt_valid_i,
  input  logic              evt_err_i,
  input  logic              cmd_arm_i,
  input  logic              cmd_stop_i,
  input  logic              cmd_clear_i,
  input  logic [ADDR_W-1:0] trig_addr_i,
  input  logic [ADDR_W-1:0] trig_mask_i,
  input  logic [AW-1:0]     post_cnt_i,
  output logic [1:0]        state_o,
  output logic              triggered_o,
  output logic [AW:0]       fill_o,
`ifdef AUD_TRACE_TS_EN
  output logic [ADDR_W+17:0] rd_data_o,
`else
  output logic [ADDR_W+1:0]  rd_data_o,
`endif
  output logic              rd_valid_o,
  input  logic              rd_ready_i
);

`ifdef AUD_TRACE_TS_EN
  localparam int DW = ADDR_W + 18;
`else
  localparam int DW = ADDR_W + 2;
`endif
  localparam int          DEPTH = 1 << AW;
  localparam logic [AW:0] FULL  = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            trig_q, trig_d;
  logic [AW:0]     fill_q, fill_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   post_q, post_d;
  logic            rd_valid_q, rd_valid_d;
  logic            primed_q, primed_d;
  logic [DW-1:0]   rd_data_q;

  logic            live, wr_en, trig_hit, hs, stop_go, arm_go, rd_load;
  logic [AW-1:0]   rd_addr;
  logic [DW-1:0]   entry_w;
  logic [DW-1:0]   mem [DEPTH];

  assign live     = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign wr_en    = evt_stb_i && live && !cmd_clear_i;
  assign trig_hit = evt_stb_i && evt_valid_i && !evt_err_i &&
                    (((evt_addr_i ^ trig_addr_i) & trig_mask_i) == '0);
  assign hs       = rd_valid_q && rd_ready_i;
  assign stop_go  = cmd_stop_i && !cmd_clear_i && live;
  assign arm_go   = cmd_arm_i && !cmd_clear_i && !live;

`ifdef AUD_TRACE_TS_EN
  logic [15:0] ts_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ts_q <= '0;
    else if (arm_go) ts_q <= '0;
    else             ts_q <= ts_q + 16'd1;
  end
  assign entry_w = {ts_q, evt_err_i, evt_valid_i, evt_addr_i};
`else
  assign entry_w = {evt_err_i, evt_valid_i, evt_addr_i};
`endif

  always_comb begin
    state_d  = state_q;
    trig_d   = trig_q;
    fill_d   = fill_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    post_d   = post_q;
    // the write of the current event happens regardless of a coincident stop
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (fill_q != FULL) fill_d = fill_q + 1'b1;
    end
    if (cmd_clear_i) begin
      state_d  = S_IDLE;
      trig_d   = 1'b0;
      fill_d   = '0;
      wr_ptr_d = '0;
    end else if (stop_go) begin
      state_d = S_DONE;
    end else if (arm_go) begin
      state_d  = S_ARMED;
      trig_d   = 1'b0;
      fill_d   = '0;
      wr_ptr_d = '0;
    end else begin
      unique case (state_q)
        S_ARMED: if (trig_hit) begin
          trig_d  = 1'b1;
          post_d  = post_cnt_i;
          state_d = (post_cnt_i == '0) ? S_DONE : S_CAPTURE;
        end
        S_CAPTURE: if (evt_stb_i) begin
          post_d = post_q - 1'b1;
          if (post_q <= AW'(1)) state_d = S_DONE;
        end
        S_DONE: if (hs) begin
          fill_d   = fill_q - 1'b1;
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
        default: ;
      endcase
    end
    // oldest entry; a full buffer gives wr_ptr itself since fill truncates to 0
    if (state_q != S_DONE) rd_ptr_d = wr_ptr_d - fill_d[AW-1:0];

    primed_d   = (state_q == S_DONE) && (state_d == S_DONE);
    rd_valid_d = primed_d && (rd_valid_q ? !rd_ready_i : (primed_q && fill_q != '0));
  end

  // prefetch the next entry on a handshake so the following word lands one cycle later
  assign rd_addr = hs ? rd_ptr_q + 1'b1 : rd_ptr_q;
  assign rd_load = (state_q == S_DONE) && !(rd_valid_q && !rd_ready_i);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= entry_w;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      trig_q     <= 1'b0;
      fill_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      post_q     <= '0;
      rd_valid_q <= 1'b0;
      primed_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      trig_q     <= trig_d;
      fill_q     <= fill_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      post_q     <= post_d;
      rd_valid_q <= rd_valid_d;
      primed_q   <= primed_d;
      if (rd_load) rd_data_q <= mem[rd_addr];
    end
  end

  assign state_o     = state_q;
  assign triggered_o = trig_q;
  assign fill_o      = fill_q;
  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;

endmodule

// File: tb/tb_aud_trace_ctrl.sv
// Directed bench for aud_trace_ctrl; stored entries are modelled in a scoreboard queue
// and compared oldest-first as the host read port drains them.
module tb_aud_trace_ctrl;
  localparam int AW     = 9;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 1 << AW;
  localparam int EW     = ADDR_W + 2;
`ifdef AUD_TRACE_TS_EN
  localparam int DW = ADDR_W + 18;
`else
  localparam int DW = ADDR_W + 2;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              evt_stb = 0, evt_valid = 0, evt_err = 0;
  logic [ADDR_W-1:0] evt_addr = '0, trig_addr = '0, trig_mask = '0;
  logic              cmd_arm = 0, cmd_stop = 0, cmd_clear = 0, rd_ready = 0;
  logic [AW-1:0]     post_cnt = '0;
  logic [1:0]        state_o;
  logic              triggered_o, rd_valid_o;
  logic [AW:0]       fill_o;
  logic [DW-1:0]     rd_data_o;

  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  aud_trace_ctrl #(.AW(AW), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .evt_stb_i(evt_stb), .evt_addr_i(evt_addr), .evt_valid_i(evt_valid), .evt_err_i(evt_err),
    .cmd_arm_i(cmd_arm), .cmd_stop_i(cmd_stop), .cmd_clear_i(cmd_clear),
    .trig_addr_i(trig_addr), .trig_mask_i(trig_mask), .post_cnt_i(post_cnt),
    .state_o(state_o), .triggered_o(triggered_o), .fill_o(fill_o),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic evt(input logic [ADDR_W-1:0] a, input logic v, input logic e, input bit st);
    evt_stb = 1; evt_addr = a; evt_valid = v; evt_err = e;
    tick();
    evt_stb = 0; evt_valid = 0; evt_err = 0;
    if (st) begin
      exp_q.push_back({e, v, a});
      if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
    end
  endtask

  task automatic arm();
    cmd_arm = 1; tick(); cmd_arm = 0;
    exp_q.delete();
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!rd_valid_o && n < 8) begin tick(); n++; end
    chk(tag, {63'd0, rd_valid_o}, 64'd1);
  endtask

  // drain n entries with rd_ready high; checks data order and 2-clk handshake spacing
  task automatic drain(input string tag, input int n);
    int got = 0, cyc = 0, last = -1;
    logic [EW-1:0] e;
    rd_ready = 1;
    while (got < n && cyc < 4 * n + 20) begin
      if (rd_valid_o) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        chk(tag, {30'd0, rd_data_o[EW-1:0]}, {30'd0, e});
        if (last >= 0) chk("rd_spacing", 64'(cyc - last), 64'd2);
        last = cyc;
        got++;
      end
      tick(); cyc++;
    end
    rd_ready = 0;
    chk("drain_count", 64'(got), 64'(n));
    chk("drain_fill0", 64'(fill_o), 64'd0);
    chk("drain_rv0", {63'd0, rd_valid_o}, 64'd0);
  endtask

  initial begin
    logic [DW-1:0] d0;
    // reset values
    tick(); tick();
    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_trig", {63'd0, triggered_o}, 64'd0);
    chk("rst_fill", 64'(fill_o), 64'd0);
    chk("rst_rv", {63'd0, rd_valid_o}, 64'd0);
    chk("rst_rdata", 64'(rd_data_o), 64'd0);
    rst = 0;
    tick();

    // A: match-any trigger, post_cnt=3, 5th event after DONE is dropped
    trig_mask = '0; post_cnt = 3;
    arm();
    chk("A_armed", 64'(state_o), 64'd1);
    evt(32'h100, 1, 0, 1);
    chk("A_capture", 64'(state_o), 64'd2);
    chk("A_trig", {63'd0, triggered_o}, 64'd1);
    evt(32'h200, 1, 0, 1);
    evt(32'h300, 0, 1, 1);
    evt(32'h400, 1, 0, 1);
    chk("A_done", 64'(state_o), 64'd3);
    evt(32'h500, 1, 0, 0);
    chk("A_fill", 64'(fill_o), 64'd4);
    drain("A_data", 4);

    // B: 700 events, never matching, then stop -> oldest kept is event 189
    trig_addr = '1; trig_mask = '1;
    arm();
    for (int i = 1; i <= 700; i++) evt(ADDR_W'(i), 1, 0, 1);
    chk("B_armed", 64'(state_o), 64'd1);
    chk("B_notrig", {63'd0, triggered_o}, 64'd0);
    chk("B_fill", 64'(fill_o), 64'd512);
    cmd_stop = 1; tick(); cmd_stop = 0;
    chk("B_done", 64'(state_o), 64'd3);
    chk("B_rv_e0", {63'd0, rd_valid_o}, 64'd0);
    tick();
    chk("B_rv_e1", {63'd0, rd_valid_o}, 64'd0);
    tick();
    chk("B_rv_e2", {63'd0, rd_valid_o}, 64'd1);
    chk("B_first", 64'(rd_data_o[ADDR_W-1:0]), 64'd189);
    drain("B_data", 512);

    // C: masked trigger; invalid and error events stored but don't trigger
    cmd_clear = 1; tick(); cmd_clear = 0;
    chk("C_idle", 64'(state_o), 64'd0);
    evt(32'h0C00100C, 1, 0, 0);
    chk("C_idle_ign", 64'(fill_o), 64'd0);
    trig_addr = 32'h0C001000; trig_mask = 32'hFFFFFFF0; post_cnt = 2;
    arm();
    evt(32'h0C00100C, 0, 0, 1);
    chk("C_nv_state", 64'(state_o), 64'd1);
    chk("C_nv_trig", {63'd0, triggered_o}, 64'd0);
    evt(32'h0C00100C, 1, 1, 1);
    chk("C_err_state", 64'(state_o), 64'd1);
    evt(32'h0C00100C, 1, 0, 1);
    chk("C_trig", {63'd0, triggered_o}, 64'd1);
    chk("C_capture", 64'(state_o), 64'd2);
    evt(32'h0C002000, 1, 0, 1);
    chk("C_cap2", 64'(state_o), 64'd2);
    evt(32'h12345678, 1, 0, 1);
    chk("C_done", 64'(state_o), 64'd3);
    chk("C_fill", 64'(fill_o), 64'd5);
    drain("C_data", 5);

    // D: fill=2, host stalls 10 clk, then two handshakes
    trig_mask = '0; post_cnt = 1;
    arm();
    evt(32'hA5A50001, 1, 0, 1);
    evt(32'h5A5A0002, 1, 0, 1);
    chk("D_done", 64'(state_o), 64'd3);
    chk("D_fill", 64'(fill_o), 64'd2);
    wait_valid("D_valid");
    d0 = rd_data_o;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("D_hold_rv", {63'd0, rd_valid_o}, 64'd1);
      chk("D_hold_data", 64'(rd_data_o), 64'(d0));
    end
    drain("D_data", 2);
    chk("D_state", 64'(state_o), 64'd3);

    // E: stop coincident with event; then clear mid-readout
    trig_addr = '1; trig_mask = '1;
    arm();
    evt(32'h11, 1, 0, 1);
    evt(32'h22, 1, 0, 1);
    cmd_stop = 1;
    evt(32'h33, 1, 0, 1);
    cmd_stop = 0;
    chk("E_done", 64'(state_o), 64'd3);
    chk("E_fill", 64'(fill_o), 64'd3);
    wait_valid("E_valid");
    chk("E_first", {30'd0, rd_data_o[EW-1:0]}, {30'd0, exp_q[0]});
    cmd_clear = 1; tick(); cmd_clear = 0;
    exp_q.delete();
    chk("E_clr_rv", {63'd0, rd_valid_o}, 64'd0);
    chk("E_clr_state", 64'(state_o), 64'd0);
    chk("E_clr_fill", 64'(fill_o), 64'd0);

    // F: post_cnt=0 goes straight to DONE
    trig_mask = '0; post_cnt = 0;
    arm();
    evt(32'hBEEF, 1, 0, 1);
    chk("F_done", 64'(state_o), 64'd3);
    chk("F_fill", 64'(fill_o), 64'd1);
    drain("F_data", 1);

    // G: async reset during CAPTURE, checked before the next clock edge
    post_cnt = 5;
    arm();
    evt(32'h1, 1, 0, 1);
    evt(32'h2, 1, 0, 1);
    chk("G_capture", 64'(state_o), 64'd2);
    #3 rst = 1;
    #1;
    chk("G_state", 64'(state_o), 64'd0);
    chk("G_fill", 64'(fill_o), 64'd0);
    chk("G_rv", {63'd0, rd_valid_o}, 64'd0);
    chk("G_trig", {63'd0, triggered_o}, 64'd0);
    tick();
    rst = 0;
    exp_q.delete();
    tick();
    chk("G_idle", 64'(state_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
